// File: rtl/idex_hazard_stage_if.sv
// ID/EX stage bundle: decoded ID fields and pipe control in, EX fields and stall status out.
interface idex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              idValid;
  logic [3:0]        idInstrType;
  logic [4:0]        idRS;
  logic [4:0]        idRT;
  logic [4:0]        idRegDest;
  logic [DATA_W-1:0] idRSData;
  logic [DATA_W-1:0] idRTData;
  logic              flush;
  logic              memStall;
  logic              exValid;
  logic [3:0]        exInstrType;
  logic [4:0]        exRS;
  logic [4:0]        exRT;
  logic [4:0]        exRegDest;
  logic [DATA_W-1:0] exRSData;
  logic [DATA_W-1:0] exRTData;
  logic              stallFront;
  logic [CNT_W-1:0]  loadUseCnt;

  modport master (
    output idValid, idInstrType, idRS, idRT, idRegDest, idRSData, idRTData, flush, memStall,
    input  exValid, exInstrType, exRS, exRT, exRegDest, exRSData, exRTData, stallFront, loadUseCnt
  );

  modport slave (
    input  idValid, idInstrType, idRS, idRT, idRegDest, idRSData, idRTData, flush, memStall,
    output exValid, exInstrType, exRS, exRT, exRegDest, exRSData, exRTData, stallFront, loadUseCnt
  );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use detection: one-cycle ID->EX latency, a single bubble
// per dependent load, EX flush on taken branch/jump, and a full freeze while memStall is high.
module idex_hazard_stage #(
  parameter logic [3:0] LOAD_TYPE   = 4'd2,
  parameter logic [3:0] BUBBLE_TYPE = 4'd3,
  parameter int         DATA_W      = 32,
  parameter int         CNT_W       = 16
) (
  input logic                clk,
  input logic                rst,
  idex_hazard_stage_if.slave bus
);
  typedef enum logic {RUN, LU_BUBBLE} state_t;

  state_t            state;
  logic              ex_valid;
  logic [3:0]        ex_type;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [CNT_W-1:0]  lu_cnt;

  logic uses_rs;
  logic uses_rt;
  logic load_use;
  logic insert_bubble;

  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b1;
    case (bus.idInstrType)
      4'd4, 4'd5, 4'd9, 4'd10, 4'd11: begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
      4'd1, 4'd6: uses_rt = 1'b0;
      default: ;
    endcase
  end

  // Register 0 is hard-wired, so a load targeting it can never create a dependency.
  assign load_use = bus.idValid && ex_valid && (ex_type == LOAD_TYPE) && (ex_rd != 5'd0) &&
                    ((uses_rs && (bus.idRS == ex_rd)) || (uses_rt && (bus.idRT == ex_rd)));

  assign insert_bubble  = load_use && (state == RUN) && !bus.flush;
  assign bus.stallFront = bus.memStall || insert_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ex_valid   <= 1'b0;
      ex_type    <= BUBBLE_TYPE;
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_rd      <= 5'd0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      lu_cnt     <= '0;
    end else if (!bus.memStall) begin
      if (bus.flush || insert_bubble) begin
        ex_valid   <= 1'b0;
        ex_type    <= BUBBLE_TYPE;
        ex_rs      <= 5'd0;
        ex_rt      <= 5'd0;
        ex_rd      <= 5'd0;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
      end else begin
        ex_valid   <= bus.idValid;
        ex_type    <= bus.idInstrType;
        ex_rs      <= bus.idRS;
        ex_rt      <= bus.idRT;
        ex_rd      <= bus.idRegDest;
        ex_rs_data <= bus.idRSData;
        ex_rt_data <= bus.idRTData;
      end
      state <= insert_bubble ? LU_BUBBLE : RUN;
      if (insert_bubble && (lu_cnt != {CNT_W{1'b1}}))
        lu_cnt <= lu_cnt + CNT_W'(1);
    end
  end

  assign bus.exValid     = ex_valid;
  assign bus.exInstrType = ex_type;
  assign bus.exRS        = ex_rs;
  assign bus.exRT        = ex_rt;
  assign bus.exRegDest   = ex_rd;
  assign bus.exRSData    = ex_rs_data;
  assign bus.exRTData    = ex_rt_data;
  assign bus.loadUseCnt  = lu_cnt;
endmodule

// File: tb/tb_idex_hazard_stage.sv
// Self-checking bench for idex_hazard_stage: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model; a narrow-counter twin checks saturation.
module tb_idex_hazard_stage;
  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idex_hazard_stage_if #(.DATA_W(32), .CNT_W(16))    bus ();
  idex_hazard_stage_if #(.DATA_W(32), .CNT_W(SAT_W)) bus_s ();

  assign bus_s.idValid     = bus.idValid;
  assign bus_s.idInstrType = bus.idInstrType;
  assign bus_s.idRS        = bus.idRS;
  assign bus_s.idRT        = bus.idRT;
  assign bus_s.idRegDest   = bus.idRegDest;
  assign bus_s.idRSData    = bus.idRSData;
  assign bus_s.idRTData    = bus.idRTData;
  assign bus_s.flush       = bus.flush;
  assign bus_s.memStall    = bus.memStall;

  idex_hazard_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  idex_hazard_stage #(.DATA_W(32), .CNT_W(SAT_W)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  typedef struct {
    logic        v;
    logic [3:0]  t;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } fields_t;

  typedef struct {
    fields_t id;
    logic    fl;
    logic    ms;
    logic    exp_stall;
    fields_t exp_ex;
    int      exp_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic fields_t f(logic v, logic [3:0] t, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [31:0] a, logic [31:0] b);
    fields_t r;
    r.v = v; r.t = t; r.rs = rs; r.rt = rt; r.rd = rd; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic vec_t mkv(fields_t id, logic fl, logic ms, logic st, fields_t ex, int cnt);
    vec_t r;
    r.id = id; r.fl = fl; r.ms = ms; r.exp_stall = st; r.exp_ex = ex; r.exp_cnt = cnt;
    return r;
  endfunction

  function automatic logic [127:0] expv(fields_t e, int cnt);
    logic [15:0] c;
    c = 16'(cnt);
    return 128'({e.v, e.t, e.rs, e.rt, e.rd, e.a, e.b, c});
  endfunction

  function automatic logic [127:0] obs();
    return 128'({bus.exValid, bus.exInstrType, bus.exRS, bus.exRT, bus.exRegDest,
                 bus.exRSData, bus.exRTData, bus.loadUseCnt});
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input fields_t id, input logic fl, input logic ms);
    bus.idValid     = id.v;
    bus.idInstrType = id.t;
    bus.idRS        = id.rs;
    bus.idRT        = id.rt;
    bus.idRegDest   = id.rd;
    bus.idRSData    = id.a;
    bus.idRTData    = id.b;
    bus.flush       = fl;
    bus.memStall    = ms;
  endtask

  function automatic bit uses_rs(logic [3:0] t);
    return !(t inside {4'd4, 4'd5, 4'd9, 4'd10, 4'd11});
  endfunction

  function automatic bit uses_rt(logic [3:0] t);
    return !(t inside {4'd1, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11});
  endfunction

  vec_t    tbl [19];
  fields_t bub;
  fields_t m_ex;
  fields_t rid;
  bit      m_after_bubble;
  int      m_cnt;

  initial begin
    bub = f(1'b0, 4'd3, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    // Directed sequence: normal flow, load-use, false-stall cases, flush, freeze, invalid ID.
    tbl[0]  = mkv(f(1, 0, 3, 4, 5, 32'h11, 32'h22), 0, 0, 0, f(1, 0, 3, 4, 5, 32'h11, 32'h22), 0);
    tbl[1]  = mkv(f(1, 2, 1, 0, 7, 32'hA, 32'hB), 0, 0, 0, f(1, 2, 1, 0, 7, 32'hA, 32'hB), 0);
    tbl[2]  = mkv(f(1, 0, 7, 4, 8, 32'h33, 32'h44), 0, 0, 1, bub, 1);
    tbl[3]  = mkv(f(1, 0, 7, 4, 8, 32'h33, 32'h44), 0, 0, 0, f(1, 0, 7, 4, 8, 32'h33, 32'h44), 1);
    tbl[4]  = mkv(f(1, 2, 1, 2, 0, 32'h1, 32'h2), 0, 0, 0, f(1, 2, 1, 2, 0, 32'h1, 32'h2), 1);
    tbl[5]  = mkv(f(1, 0, 0, 0, 9, 32'h5, 32'h6), 0, 0, 0, f(1, 0, 0, 0, 9, 32'h5, 32'h6), 1);
    tbl[6]  = mkv(f(1, 2, 1, 1, 7, 32'h7, 32'h8), 0, 0, 0, f(1, 2, 1, 1, 7, 32'h7, 32'h8), 1);
    tbl[7]  = mkv(f(1, 4, 7, 7, 31, 32'h9, 32'hA), 0, 0, 0, f(1, 4, 7, 7, 31, 32'h9, 32'hA), 1);
    tbl[8]  = mkv(f(1, 2, 1, 1, 7, 32'h7, 32'h8), 0, 0, 0, f(1, 2, 1, 1, 7, 32'h7, 32'h8), 1);
    tbl[9]  = mkv(f(1, 0, 7, 0, 10, 32'h1, 32'h1), 1, 0, 0, bub, 1);
    tbl[10] = mkv(f(1, 2, 2, 3, 6, 32'hC, 32'hD), 0, 0, 0, f(1, 2, 2, 3, 6, 32'hC, 32'hD), 1);
    tbl[11] = mkv(f(1, 0, 1, 6, 12, 32'hE, 32'hF), 0, 1, 1, f(1, 2, 2, 3, 6, 32'hC, 32'hD), 1);
    tbl[12] = tbl[11];
    tbl[13] = tbl[11];
    tbl[14] = mkv(f(1, 0, 1, 6, 12, 32'hE, 32'hF), 0, 0, 1, bub, 2);
    tbl[15] = mkv(f(1, 0, 1, 6, 12, 32'hE, 32'hF), 0, 0, 0, f(1, 0, 1, 6, 12, 32'hE, 32'hF), 2);
    tbl[16] = mkv(f(0, 5, 1, 2, 3, 32'h1, 32'h2), 0, 0, 0, f(0, 5, 1, 2, 3, 32'h1, 32'h2), 2);
    tbl[17] = mkv(f(1, 2, 0, 0, 4, 32'h0, 32'h0), 0, 0, 0, f(1, 2, 0, 0, 4, 32'h0, 32'h0), 2);
    tbl[18] = mkv(f(0, 0, 4, 4, 1, 32'h3, 32'h3), 0, 0, 0, f(0, 0, 4, 4, 1, 32'h3, 32'h3), 2);

    drive(bub, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ex", obs(), expv(bub, 0));
    check("reset_stall", 128'(bus.stallFront), 128'(1'b0));

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].id, tbl[i].fl, tbl[i].ms);
      #1;
      check($sformatf("vec%0d_stall", i), 128'(bus.stallFront), 128'(tbl[i].exp_stall));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ex", i), obs(), expv(tbl[i].exp_ex, tbl[i].exp_cnt));
    end

    // Reset arriving while a load-use stall is pending.
    @(negedge clk);
    drive(f(1, 2, 1, 1, 7, 32'h7, 32'h8), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(f(1, 0, 7, 2, 9, 32'h55, 32'h66), 1'b0, 1'b0);
    #1;
    check("midrst_pre_stall", 128'(bus.stallFront), 128'(1'b1));
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ex", obs(), expv(bub, 0));
    check("midrst_stall", 128'(bus.stallFront), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_after", obs(), expv(f(1, 0, 7, 2, 9, 32'h55, 32'h66), 0));

    // Randomized traffic against the behavioural model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_ex = bub;
    m_after_bubble = 1'b0;
    m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bit hazard;
      bit fl;
      bit ms;
      bit exp_st;
      int sat_exp;
      @(negedge clk);
      rid.v  = ($urandom_range(0, 7) != 0);
      rid.t  = ($urandom_range(0, 2) == 0) ? 4'd2 : 4'($urandom_range(0, 11));
      rid.rs = 5'($urandom_range(0, 3));
      rid.rt = 5'($urandom_range(0, 3));
      rid.rd = 5'($urandom_range(0, 3));
      rid.a  = $urandom;
      rid.b  = $urandom;
      fl = ($urandom_range(0, 11) == 0);
      ms = ($urandom_range(0, 5) == 0);
      drive(rid, fl, ms);
      hazard = rid.v && m_ex.v && (m_ex.t == 4'd2) && (m_ex.rd != 0) && !m_after_bubble &&
               ((uses_rs(rid.t) && rid.rs == m_ex.rd) || (uses_rt(rid.t) && rid.rt == m_ex.rd));
      exp_st = ms || (!fl && hazard);
      #1;
      check("rand_stall", 128'(bus.stallFront), 128'(exp_st));
      @(posedge clk);
      if (!ms) begin
        if (fl) begin
          m_ex = bub;
          m_after_bubble = 1'b0;
        end else if (hazard) begin
          m_ex = bub;
          m_after_bubble = 1'b1;
          m_cnt++;
        end else begin
          m_ex = rid;
          m_after_bubble = 1'b0;
        end
      end
      #1;
      check("rand_ex", obs(), expv(m_ex, (m_cnt > 65535) ? 65535 : m_cnt));
      sat_exp = (m_cnt > 15) ? 15 : m_cnt;
      check("rand_sat_cnt", 128'(bus_s.loadUseCnt), 128'(sat_exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection for the 5-stage core.
- Captures decoded fields from ID every cycle and presents them to EX. The EX-side type/RS/RT/RegDest outputs feed the forwarding unit directly.
- Forwarding cannot resolve a load followed by a dependent use. For that case this block stalls IF/ID and inserts one bubble into EX.
- Also handles branch/jump flush from EX and global memory-stall freeze.

Parameters:
- LOAD_TYPE, 4'd2, instrType code of load-word (result available only after MEM).
- BUBBLE_TYPE, 4'd3, instrType loaded for a bubble (non-writing type; with RegDest=0 it never forwards).
- DATA_W, 32, operand data width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- idValid  in  1  ID holds a real instruction.
- idInstrType  in  4  decoded type of the ID instruction.
- idRS, idRT, idRegDest  in  5 each  ID register specifiers.
- idRSData, idRTData  in  DATA_W each  register-file read data.
- flush  in  1  taken branch/jump resolved in EX; squash the younger instruction.
- memStall  in  1  memory stage busy; freeze the whole pipe.
- exValid  out  1  EX holds a real instruction.
- exInstrType  out  4  to EX and the forwarding unit.
- exRS, exRT, exRegDest  out  5 each  to EX and the forwarding unit.
- exRSData, exRTData  out  DATA_W each  operand data.
- stallFront  out  1  hold PC and the IF/ID register this cycle (combinational).
- loadUseCnt  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, immediate): exValid=0, exInstrType=BUBBLE_TYPE, exRS/exRT/exRegDest=0, data=0, loadUseCnt=0, state=RUN.
- Latency: 1 cycle, ID to EX.
- Operand use by the ID instruction:
  - idUsesRS = type not in {4,5,9,10,11}.
  - idUsesRT = type not in {1,4,5,6,9,10,11}.
- loadUse is true when all of the following hold:
  - idValid & exValid & exInstrType==LOAD_TYPE & exRegDest!=0;
  - (idUsesRS & idRS==exRegDest) | (idUsesRT & idRT==exRegDest).
- Per-cycle priority, highest first:
  1. memStall=1: all EX registers hold, stallFront=1, state and counter unchanged.
  2. flush=1: EX loads a bubble (exValid=0, type=BUBBLE_TYPE, RS/RT/RegDest=0, data=0); stallFront=0; loadUse ignored; state→RUN.
  3. loadUse=1 with state RUN:
     - EX loads a bubble; stallFront=1; state→LU_BUBBLE.
     - loadUseCnt += 1, saturating at all-ones.
  4. Otherwise: EX loads the ID fields, exValid=idValid; stallFront=0; state→RUN.
- FSM:
  - RUN: normal operation.
  - LU_BUBBLE: exactly one bubble has been inserted. Next non-frozen cycle loads the held ID instruction and returns to RUN.
  - A loadUse in LU_BUBBLE is impossible because EX holds a bubble. Treat it as normal advance without stalling; the guarantee is a single bubble per load.
- stallFront is combinational from the current inputs and EX registers. It never depends on the next state.
- idValid=0 never triggers loadUse. An invalid ID slot still advances, producing exValid=0 with the fields copied.
- Register 0 never causes a stall.
- Reset asserted mid-stall returns to RUN with a bubble in EX. Deassertion needs no special sequencing.

Test Plan:
- Reset: assert rst mid-cycle → all outputs at reset values immediately; loadUseCnt=0.
- Normal flow: ID add (type 0, RS=3, RT=4, RD=5, data 0x11/0x22) → next edge: exValid=1, exRS=3, exRT=4, exRegDest=5, data 0x11/0x22; stallFront=0.
- Load-use: EX load (type 2, RD=7); ID type 0 with RS=7:
  - same cycle: stallFront=1;
  - next edge: EX bubble, loadUseCnt=1;
  - following edge: add enters EX with RS=7, stallFront=0.
- No false stall: EX load RD=0 with ID RS=0 → stallFront=0. EX load RD=7 with ID type 4 (jump) RS=7 → stallFront=0.
- Flush over hazard: load-use condition plus flush=1 → stallFront=0, EX bubble, loadUseCnt unchanged.
- Freeze and saturation:
  - memStall=1 for 3 cycles during a load-use → EX outputs and counter constant, stallFront=1; after release, a single bubble, then the dependent instruction enters EX.
  - Preload the counter to 0xFFFF → stays at 0xFFFF on the next bubble.
